// File: rtl/temp_conv_pkg.sv
// Shared definitions for the temperature conversion scheduler.
//   conv_state_t : scheduler FSM states
//   temp_fmt_t   : request format (F->C = 0, C->F = 1)
//   C_/F_ limits : legal input ranges, F_BASE_DEF : ROM base of the F->C table
//   in_range()   : legality check for a (temperature, format) pair
package temp_conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } conv_state_t;

    typedef enum logic {
        FMT_F2C = 1'b0,
        FMT_C2F = 1'b1
    } temp_fmt_t;

    localparam int unsigned C_MIN      = 0;
    localparam int unsigned C_MAX      = 100;
    localparam int unsigned F_MIN      = 32;
    localparam int unsigned F_MAX      = 212;
    localparam int unsigned F_BASE_DEF = 128;

    // C_MIN is 0, so the lower Celsius bound is implied by the unsigned input.
    function automatic logic in_range(input int unsigned t, input temp_fmt_t f);
        if (f == FMT_C2F) return (t <= C_MAX);
        else              return (t >= F_MIN) && (t <= F_MAX);
    endfunction

endpackage

// File: rtl/temp_conv_sched_if.sv
// Request/response bundle between the two requesters, the response consumer
// and the scheduler.
//   master : requester/consumer side (drives requests and resp_ready)
//   slave  : scheduler side (drives req_ready and the response)
interface temp_conv_sched_if #(
    parameter int SIZE = 8
);
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [1:0][SIZE-1:0] req_temp;
    logic [1:0]           req_fmt;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [SIZE-1:0]      resp_data;
    logic                 resp_id;
    logic                 resp_err;

    modport master (
        output req_valid, req_temp, req_fmt, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_id, resp_err
    );

    modport slave (
        input  req_valid, req_temp, req_fmt, resp_ready,
        output req_ready, resp_valid, resp_data, resp_id, resp_err
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst : clock, async active-low reset
//   en       : arbitration allowed this cycle (scheduler idle)
//   req      : request vector
//   advance  : pulse on handshake; records the current grant as last grant
//   gnt      : one-hot or zero grant, combinational from req/en/last grant
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    logic last_q, last_d;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                // tie: serve whoever was not granted last
                2'b11:   gnt = last_q ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
        last_d = advance ? gnt[1] : last_q;
    end

    // last grant starts at 1 so requester 0 wins the first tie
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last_q <= 1'b1;
        else      last_q <= last_d;
    end
endmodule

// File: rtl/temp_conv_sched.sv
// Shares one synchronous conversion ROM between two requesters.
//   clk, rst   : clock, async active-low reset
//   bus        : request/response interface (slave side)
//   rom_en     : ROM read enable, high for the single READ cycle
//   rom_addr   : ROM address, holds its last value outside READ
//   rom_data   : ROM read data, valid ROM_LAT cycles after rom_en
//   busy       : FSM not idle
// Flow: IDLE -(grant)-> READ -> WAIT(ROM_LAT) -> RESP -> IDLE; an out-of-range
// request goes IDLE -> RESP with data 0 and err set, without touching the ROM.
module temp_conv_sched
    import temp_conv_pkg::*;
#(
    parameter int SIZE    = 8,
    parameter int ADDR_W  = 9,
    parameter int ROM_LAT = 1,
    parameter int F_BASE  = F_BASE_DEF
) (
    input  logic                clk,
    input  logic                rst,
    temp_conv_sched_if.slave    bus,
    output logic                rom_en,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [SIZE-1:0]     rom_data,
    output logic                busy
);
    localparam int CNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    conv_state_t       state_q, state_d;
    logic [SIZE-1:0]   temp_q, temp_d;
    temp_fmt_t         fmt_q, fmt_d;
    logic              id_q, id_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [SIZE-1:0]   resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;

    logic [1:0]        gnt;
    logic              hs;
    logic              sel_id;
    logic [SIZE-1:0]   sel_temp;
    temp_fmt_t         sel_fmt;
    logic [ADDR_W-1:0] map_addr;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .en      (state_q == ST_IDLE),
        .req     (bus.req_valid),
        .advance (hs),
        .gnt     (gnt)
    );

    assign bus.req_ready = gnt;
    assign hs            = |gnt;
    assign sel_id        = gnt[1];
    assign sel_temp      = bus.req_temp[sel_id];
    assign sel_fmt       = temp_fmt_t'(bus.req_fmt[sel_id]);

    // F->C entries start at F_BASE for 32F; wraps at ADDR_W bits by design
    assign map_addr = (fmt_q == FMT_C2F) ? ADDR_W'(temp_q)
                    : ADDR_W'(F_BASE) + ADDR_W'(temp_q) - ADDR_W'(F_MIN);

    always_comb begin
        state_d     = state_q;
        temp_d      = temp_q;
        fmt_d       = fmt_q;
        id_d        = id_q;
        wcnt_d      = wcnt_q;
        rom_addr_d  = rom_addr_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        rom_en      = 1'b0;
        rom_addr    = rom_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    temp_d = sel_temp;
                    fmt_d  = sel_fmt;
                    id_d   = sel_id;
                    // checked on the value being captured so the error
                    // response can be presented the very next cycle
                    if (in_range(32'(sel_temp), sel_fmt)) begin
                        state_d = ST_READ;
                    end else begin
                        state_d     = ST_RESP;
                        resp_data_d = '0;
                        resp_err_d  = 1'b1;
                    end
                end
            end
            ST_READ: begin
                rom_en     = 1'b1;
                rom_addr   = map_addr;
                rom_addr_d = map_addr;
                wcnt_d     = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (wcnt_q == CNT_W'(ROM_LAT - 1)) begin
                    resp_data_d = rom_data;
                    resp_err_d  = 1'b0;
                    wcnt_d      = '0;
                    state_d     = ST_RESP;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            temp_q      <= '0;
            fmt_q       <= FMT_F2C;
            id_q        <= 1'b0;
            wcnt_q      <= '0;
            rom_addr_q  <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            temp_q      <= temp_d;
            fmt_q       <= fmt_d;
            id_q        <= id_d;
            wcnt_q      <= wcnt_d;
            rom_addr_q  <= rom_addr_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_id    = id_q;
    assign bus.resp_err   = resp_err_q;
    assign busy           = (state_q != ST_IDLE);
endmodule

// File: tb/tb_temp_conv_sched.sv
// Directed bench for temp_conv_sched: conversions, range errors, round-robin
// alternation, response back-pressure and reset in the middle of a read.
module tb_temp_conv_sched;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rom_en;
    logic [8:0] rom_addr;
    logic [7:0] rom_data;
    logic       busy;
    logic [7:0] rom_q = 8'd0;
    int         n_vec = 0;
    int         n_err = 0;

    temp_conv_sched_if #(.SIZE(8)) bus ();

    temp_conv_sched #(.SIZE(8), .ADDR_W(9), .ROM_LAT(1), .F_BASE(128)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .rom_en   (rom_en),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // external conversion ROM, one cycle read latency
    function automatic logic [7:0] rom_fn(input logic [8:0] a);
        int d;
        if (a <= 9'd100) return 8'((int'(a) * 18 + 5) / 10 + 32);
        if (a >= 9'd128 && a <= 9'd308) begin
            d = int'(a) - 128;
            return 8'((d * 10 + 9) / 18);
        end
        return 8'd0;
    endfunction

    always @(posedge clk) if (rom_en) rom_q <= rom_fn(rom_addr);
    assign rom_data = rom_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue from an IDLE cycle; checks the whole transaction through acceptance.
    task automatic run_req(input logic [1:0] v, input logic [7:0] t0, input logic f0,
                           input logic [7:0] t1, input logic f1, input logic exp_id,
                           input logic [7:0] exp_data, input logic exp_err,
                           input logic [8:0] exp_addr, input int stall);
        bus.req_valid   = v;
        bus.req_temp[0] = t0;  bus.req_fmt[0] = f0;
        bus.req_temp[1] = t1;  bus.req_fmt[1] = f1;
        #1;
        chk("req_ready_idle", 32'(bus.req_ready), exp_id ? 32'd2 : 32'd1);
        chk("busy_idle", 32'(busy), 32'd0);
        tick();
        // inputs may change freely once captured; a new request must wait
        bus.req_valid   = 2'b11;
        bus.req_temp[0] = 8'hff;  bus.req_fmt[0] = ~f0;
        bus.req_temp[1] = 8'hff;  bus.req_fmt[1] = ~f1;
        #1;
        chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
        chk("busy_t1", 32'(busy), 32'd1);
        chk("rom_addr_t1", 32'(rom_addr), 32'(exp_addr));
        if (exp_err) begin
            chk("rom_en_err", 32'(rom_en), 32'd0);
            chk("resp_valid_err_t1", 32'(bus.resp_valid), 32'd1);
        end else begin
            chk("rom_en_read", 32'(rom_en), 32'd1);
            chk("resp_valid_read", 32'(bus.resp_valid), 32'd0);
            tick();
            chk("rom_en_wait", 32'(rom_en), 32'd0);
            chk("resp_valid_wait", 32'(bus.resp_valid), 32'd0);
            chk("req_ready_wait", 32'(bus.req_ready), 32'd0);
            tick();
        end
        for (int s = 0; s <= stall; s++) begin
            chk("resp_valid", 32'(bus.resp_valid), 32'd1);
            chk("resp_data", 32'(bus.resp_data), 32'(exp_data));
            chk("resp_id", 32'(bus.resp_id), 32'(exp_id));
            chk("resp_err", 32'(bus.resp_err), 32'(exp_err));
            chk("rom_en_resp", 32'(rom_en), 32'd0);
            chk("req_ready_resp", 32'(bus.req_ready), 32'd0);
            if (s < stall) tick();
        end
        bus.resp_ready = 1'b1;
        bus.req_valid  = 2'b00;
        tick();
        bus.resp_ready = 1'b0;
        chk("resp_valid_done", 32'(bus.resp_valid), 32'd0);
        chk("busy_done", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid  = 2'b00;
        bus.req_temp   = '0;
        bus.req_fmt    = 2'b00;
        bus.resp_ready = 1'b0;
        #3;
        // reset state
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_data", 32'(bus.resp_data), 32'd0);
        chk("rst_resp_id", 32'(bus.resp_id), 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_rom_en", 32'(rom_en), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        #4 rst = 1'b1;
        tick();

        // conversions: C->F 100, F->C 212 (addr 308), C->F 25
        run_req(2'b01, 8'd100, 1'b1, 8'd0,   1'b0, 1'b0, 8'd212, 1'b0, 9'd100, 0);
        run_req(2'b10, 8'd0,   1'b0, 8'd212, 1'b0, 1'b1, 8'd100, 1'b0, 9'd308, 0);
        run_req(2'b01, 8'd25,  1'b1, 8'd0,   1'b0, 1'b0, 8'd77,  1'b0, 9'd25,  0);

        // out-of-range: C->F 101 on req 0, F->C 31 on req 1; rom_addr holds 25
        run_req(2'b01, 8'd101, 1'b1, 8'd0,   1'b0, 1'b0, 8'd0,   1'b1, 9'd25,  0);
        run_req(2'b10, 8'd0,   1'b0, 8'd31,  1'b0, 1'b1, 8'd0,   1'b1, 9'd25,  0);

        // both requesting: last grant was 1, so 0,1,0,1
        run_req(2'b11, 8'd0, 1'b1, 8'd50, 1'b0, 1'b0, 8'd32, 1'b0, 9'd0,   0);
        run_req(2'b11, 8'd0, 1'b1, 8'd50, 1'b0, 1'b1, 8'd10, 1'b0, 9'd146, 0);
        run_req(2'b11, 8'd0, 1'b1, 8'd50, 1'b0, 1'b0, 8'd32, 1'b0, 9'd0,   0);
        run_req(2'b11, 8'd0, 1'b1, 8'd50, 1'b0, 1'b1, 8'd10, 1'b0, 9'd146, 0);

        // back-pressure: resp_ready low for 10 cycles, C->F 37 = 99
        run_req(2'b01, 8'd37, 1'b1, 8'd0, 1'b0, 1'b0, 8'd99, 1'b0, 9'd37, 10);

        // reset during WAIT on a request from 0 (last grant becomes 0)
        bus.req_valid   = 2'b01;
        bus.req_temp[0] = 8'd50;
        bus.req_fmt[0]  = 1'b1;
        #1;
        chk("abort_grant", 32'(bus.req_ready), 32'd1);
        tick();
        chk("abort_read", 32'(rom_en), 32'd1);
        tick();
        bus.req_valid = 2'b00;
        chk("abort_in_wait", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("mid_rst_resp_data", 32'(bus.resp_data), 32'd0);
        chk("mid_rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("mid_rst_rom_en", 32'(rom_en), 32'd0);
        chk("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
        #2 rst = 1'b1;
        tick();
        chk("post_rst_no_resp", 32'(bus.resp_valid), 32'd0);
        // pointer is back at 1: requester 0 wins the tie, C->F 50 = 122
        run_req(2'b11, 8'd50, 1'b1, 8'd100, 1'b0, 1'b0, 8'd122, 1'b0, 9'd50, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
